test_rca: RTL and testbench
===========================

// Module: test_rca
// PURPOSE
//  - WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
//  - Computes {cout, sum} = a + b + cin, with an optional one-cycle output register.
//  - Arithmetic leaf block for datapaths; the default configuration is the 4-bit adder.
// PARAMETERS
//  - WIDTH    4  operand and sum width in bits (>=1)
//  - OUT_REG  1  1: sum/cout/out_valid registered (1-cycle latency); 0: purely combinational
// PORTS
//  - clk        in   1      single clock; all state updates on rising edge
//  - rst_n      in   1      reset, synchronous, active-low
//  - in_valid   in   1      operands valid this cycle
//  - cin        in   1      carry into bit 0
//  - a          in   WIDTH  operand A, unsigned (two's complement when OVERFLOW_EN is used)
//  - b          in   WIDTH  operand B
//  - sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//  - cout       out  1      carry out of bit WIDTH-1
//  - out_valid  out  1      sum/cout correspond to an accepted operand set
//  - ovf        out  1      signed overflow; present only with OVERFLOW_EN
// BEHAVIOUR
//  - Full-adder cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
//  - Carry chain: c[0] = cin, cout = c[WIDTH]. Ripple structure; no carry lookahead.
//  - Result is exact: {cout, sum} == a + b + cin for all 2^(2*WIDTH+1) inputs.
//  - OUT_REG=1:
//    - At the rising clk edge with rst_n=0: sum=0, cout=0, out_valid=0, ovf=0.
//    - Otherwise, when in_valid=1: capture sum, cout and ovf; set out_valid=1.
//    - Otherwise, when in_valid=0: hold sum, cout and ovf; set out_valid=0.
//    - Latency is 1 cycle; throughput is 1 operand set per cycle; no backpressure.
//    - Reset asserted in the same cycle as in_valid: reset wins and the input is dropped.
//  - OUT_REG=0:
//    - Outputs are combinational: sum, cout and ovf follow a, b and cin immediately.
//    - out_valid = in_valid; clk and rst_n are unused.
//  - Wrap-around: an all-ones sum plus 1 wraps to 0 with cout=1.
//  - Inputs containing X/Z are not required to produce defined outputs.
// CONFIGURATION
//  - OVERFLOW_EN defined:
//    - ovf port exists; ovf = c[WIDTH] ^ c[WIDTH-1] (two's-complement overflow).
//    - ovf is registered or combinational exactly like sum.
//  - OVERFLOW_EN undefined:
//    - ovf port and its logic are absent.
//    - All other behaviour is unchanged.
// TESTING
//  - Exhaustive, WIDTH=4, OUT_REG=0: for i=0..511 apply
//    {a[3:2], b[3:2], a[1:0], b[1:0], cin} = i; after 5 ns check {cout, sum} == a + b + cin.
//  - Corners, WIDTH=4:
//    - a=F, b=1, cin=0 -> sum=0, cout=1
//    - a=F, b=F, cin=1 -> sum=F, cout=1
//    - a=0, b=0, cin=0 -> sum=0, cout=0
//  - OUT_REG=1:
//    - Hold rst_n=0 for 2 cycles -> outputs all 0.
//    - Then in_valid=1, a=5, b=A, cin=1 -> next cycle sum=0, cout=1, out_valid=1.
//  - Hold: after a valid add, drive in_valid=0 with new operands -> sum/cout unchanged, out_valid=0.
//  - Reset mid-stream: rst_n=0 together with in_valid=1 -> next cycle sum=0, cout=0, out_valid=0.
//  - OVERFLOW_EN:
//    - a=7, b=1, cin=0 -> sum=8, ovf=1
//    - a=8, b=8 -> sum=0, cout=1, ovf=1
//    - a=3, b=2 -> ovf=0

Source files
------------

// File: rtl/test_rca.sv
// Parameterised ripple-carry adder built from 1-bit full-adder cells.
// Define OVERFLOW_EN to add the signed-overflow output ovf.
module test_rca_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module test_rca #(
    parameter int WIDTH   = 4,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_w;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        test_rca_fa u_fa (
            .a_i(a[i]),
            .b_i(b[i]),
            .c_i(c[i]),
            .s_o(s_w[i]),
            .c_o(c[i+1])
        );
    end

`ifdef OVERFLOW_EN
    logic ovf_w;

    // Carries into and out of the sign bit disagree on overflow.
    assign ovf_w = c[WIDTH] ^ c[WIDTH-1];
`endif

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] sum_d;
        logic             cout_q;
        logic             cout_d;
        logic             vld_q;
        logic             vld_d;

        always_comb begin
            sum_d  = sum_q;
            cout_d = cout_q;
            vld_d  = in_valid;
            if (in_valid) begin
                sum_d  = s_w;
                cout_d = c[WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
                vld_q  <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                vld_q  <= vld_d;
            end
        end

        assign sum       = sum_q;
        assign cout      = cout_q;
        assign out_valid = vld_q;

`ifdef OVERFLOW_EN
        logic ovf_q;
        logic ovf_d;

        always_comb begin
            ovf_d = ovf_q;
            if (in_valid) begin
                ovf_d = ovf_w;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign ovf = ovf_q;
`endif
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign sum            = s_w;
        assign cout           = c[WIDTH];
        assign out_valid      = in_valid;
`ifdef OVERFLOW_EN
        assign ovf            = ovf_w;
`endif
    end
endmodule

// File: tb/tb_test_rca.sv
// Self-checking bench for test_rca: one combinational and one registered
// instance, checked against an arithmetic reference model.
module tb_test_rca;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [W-1:0] c_sum;
    logic         c_cout;
    logic         c_vld;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_vld;
`ifdef OVERFLOW_EN
    logic         c_ovf;
    logic         r_ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_vld;
    logic         m_ovf;

    always #5 clk = ~clk;

    test_rca #(.WIDTH(W), .OUT_REG(1'b0)) u_comb (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .cin(cin),
        .a(a),
        .b(b),
        .sum(c_sum),
        .cout(c_cout),
        .out_valid(c_vld)
`ifdef OVERFLOW_EN
        ,
        .ovf(c_ovf)
`endif
    );

    test_rca #(.WIDTH(W), .OUT_REG(1'b1)) u_reg (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .cin(cin),
        .a(a),
        .b(b),
        .sum(r_sum),
        .cout(r_cout),
        .out_valid(r_vld)
`ifdef OVERFLOW_EN
        ,
        .ovf(r_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input int x, input int y,
                                           input int ci);
        int t;
        t = x + y + ci;
        return t[W:0];
    endfunction

    function automatic logic ref_ovf(input int x, input int y,
                                     input int ci);
        int sx;
        int sy;
        int t;
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        t  = sx + sy + ci;
        return (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
    endfunction

    task automatic check_comb(input string tag);
        logic [W:0] e;
        e = ref_add(int'(a), int'(b), int'(cin));
        check({tag, "_csum"}, {28'd0, c_sum}, {28'd0, e[W-1:0]});
        check({tag, "_ccout"}, {31'd0, c_cout}, {31'd0, e[W]});
        check({tag, "_cvld"}, {31'd0, c_vld}, {31'd0, in_valid});
`ifdef OVERFLOW_EN
        check({tag, "_covf"}, {31'd0, c_ovf},
              {31'd0, ref_ovf(int'(a), int'(b), int'(cin))});
`endif
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
        logic [W:0] e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        #1;
        check_comb(tag);
        @(posedge clk);
        #1;
        e = ref_add(int'(x), int'(y), int'(ci));
        if (!r) begin
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            m_vld  = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                m_sum  = e[W-1:0];
                m_cout = e[W];
                m_ovf  = ref_ovf(int'(x), int'(y), int'(ci));
            end
        end
        check({tag, "_rsum"}, {28'd0, r_sum}, {28'd0, m_sum});
        check({tag, "_rcout"}, {31'd0, r_cout}, {31'd0, m_cout});
        check({tag, "_rvld"}, {31'd0, r_vld}, {31'd0, m_vld});
`ifdef OVERFLOW_EN
        check({tag, "_rovf"}, {31'd0, r_ovf}, {31'd0, m_ovf});
`endif
    endtask

    task automatic corner(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic ci,
                          input logic [W-1:0] es, input logic ec);
        a   = x;
        b   = y;
        cin = ci;
        #5;
        check({tag, "_sum"}, {28'd0, c_sum}, {28'd0, es});
        check({tag, "_cout"}, {31'd0, c_cout}, {31'd0, ec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] iv;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        m_sum    = '0;
        m_cout   = 1'b0;
        m_vld    = 1'b0;
        m_ovf    = 1'b0;

        step("rst0", 1'b0, 1'b0, 4'h3, 4'h9, 1'b1);
        step("rst1", 1'b0, 1'b1, 4'h6, 4'h2, 1'b0);
        step("add5a", 1'b1, 1'b1, 4'h5, 4'hA, 1'b1);
        check("dir_sum", {28'd0, r_sum}, 32'h0);
        check("dir_cout", {31'd0, r_cout}, 32'h1);
        check("dir_vld", {31'd0, r_vld}, 32'h1);
        step("hold", 1'b1, 1'b0, 4'h3, 4'h4, 1'b0);
        check("hold_sum", {28'd0, r_sum}, 32'h0);
        check("hold_cout", {31'd0, r_cout}, 32'h1);
        step("add2", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        step("midrst", 1'b0, 1'b1, 4'h7, 4'h7, 1'b0);
        check("midrst_sum", {28'd0, r_sum}, 32'h0);
        check("midrst_vld", {31'd0, r_vld}, 32'h0);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            iv  = i[8:0];
            a   = {iv[8:7], iv[4:3]};
            b   = {iv[6:5], iv[2:1]};
            cin = iv[0];
            #5;
            check_comb("exh");
        end

        corner("wrap", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        corner("max", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        corner("zero", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
`ifdef OVERFLOW_EN
        corner("ov78", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        check("ov78_ovf", {31'd0, c_ovf}, 32'h1);
        corner("ov88", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
        check("ov88_ovf", {31'd0, c_ovf}, 32'h1);
        corner("ov32", 4'h3, 4'h2, 1'b0, 4'h5, 1'b0);
        check("ov32_ovf", {31'd0, c_ovf}, 32'h0);
`endif

        step("resync", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step("rnd", ($urandom_range(15) != 0), $urandom_range(1) == 1,
                 W'($urandom), W'($urandom), $urandom_range(1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
